// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC per-sample control blocks.
// Pure declarations: no logic, no latency.
package anc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LP_WAIT  = 3'd1,
    LMS_WAIT = 3'd2,
    FIR_WAIT = 3'd3,
    DLY_WAIT = 3'd4
  } anc_seq_state_t;

  // 100 MHz core clock over a 64 kHz sample rate.
  localparam int SAMPLE_PERIOD_CYCLES   = 1562;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1500;

endpackage

// File: rtl/stage_watchdog.sv
// Loadable stall timer: cleared on load, counts while run is high, flags expire on its last cycle.
// expire is a decode of the registered count, valid in the same cycle as the final count value.
module stage_watchdog #(
  parameter int LIMIT = 1500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign expire = run && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/anc_frame_sequencer.sv
// Per-sample sequencer for the ANC chain: lowpass -> NLMS (optional) -> FIR -> delay/scale.
// One cycle of overhead per stage; stalled stages abort the frame, early samples are dropped and counted.
module anc_frame_sequencer
  import anc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int LAT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             sample_pulse_in,
  input  logic             adapt_en_in,
  input  logic             clear_in,
  input  logic             lp_done_in,
  input  logic             lms_done_in,
  input  logic             fir_done_in,
  input  logic             dly_done_in,
  output logic             lp_start_out,
  output logic             lms_start_out,
  output logic             fir_start_out,
  output logic             dly_start_out,
  output logic             busy_out,
  output logic             abort_out,
  output logic             overrun_out,
  output logic             timeout_out,
  output logic [7:0]       overrun_count_out,
  output logic [LAT_W-1:0] last_latency_out,
  output logic [LAT_W-1:0] max_latency_out
);

  anc_seq_state_t   state;
  logic             adapt_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_next;
  logic             frame_done;
  logic             new_accept;
  logic             overrun_evt;
  logic             timeout_evt;
  logic             wd_load;
  logic             wd_run;
  logic             wd_expire;

  always_comb begin
    frame_done  = (state == DLY_WAIT) && dly_done_in;
    new_accept  = sample_pulse_in && ((state == IDLE) || frame_done);
    overrun_evt = sample_pulse_in && !new_accept;
    wd_run      = (state != IDLE);
    wd_load     = new_accept
                || ((state == LP_WAIT)  && lp_done_in)
                || ((state == LMS_WAIT) && lms_done_in)
                || ((state == FIR_WAIT) && fir_done_in);
    // A matching done in the expiry cycle always beats the timeout.
    timeout_evt = wd_expire && !wd_load && !frame_done;
    lat_next    = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;
  end

  stage_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .load   (wd_load),
    .run    (wd_run),
    .expire (wd_expire)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      adapt_q          <= 1'b0;
      lp_start_out     <= 1'b0;
      lms_start_out    <= 1'b0;
      fir_start_out    <= 1'b0;
      dly_start_out    <= 1'b0;
      busy_out         <= 1'b0;
      abort_out        <= 1'b0;
      lat_cnt          <= '0;
      last_latency_out <= '0;
    end else begin
      lp_start_out  <= 1'b0;
      lms_start_out <= 1'b0;
      fir_start_out <= 1'b0;
      dly_start_out <= 1'b0;
      abort_out     <= 1'b0;

      if (new_accept) begin
        lat_cnt <= '0;
      end else if (state != IDLE) begin
        lat_cnt <= lat_next;
      end

      if (timeout_evt) begin
        state     <= IDLE;
        busy_out  <= 1'b0;
        abort_out <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (sample_pulse_in) begin
              adapt_q      <= adapt_en_in;
              lp_start_out <= 1'b1;
              busy_out     <= 1'b1;
              state        <= LP_WAIT;
            end
          end
          LP_WAIT: begin
            if (lp_done_in) begin
              if (adapt_q) begin
                lms_start_out <= 1'b1;
                state         <= LMS_WAIT;
              end else begin
                fir_start_out <= 1'b1;
                state         <= FIR_WAIT;
              end
            end
          end
          LMS_WAIT: begin
            if (lms_done_in) begin
              fir_start_out <= 1'b1;
              state         <= FIR_WAIT;
            end
          end
          FIR_WAIT: begin
            if (fir_done_in) begin
              dly_start_out <= 1'b1;
              state         <= DLY_WAIT;
            end
          end
          DLY_WAIT: begin
            if (dly_done_in) begin
              last_latency_out <= lat_next;
              if (sample_pulse_in) begin
                adapt_q      <= adapt_en_in;
                lp_start_out <= 1'b1;
                state        <= LP_WAIT;
              end else begin
                busy_out <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          default: begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  // Sticky status: a set event in the same cycle as clear_in takes precedence.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out       <= 1'b0;
      timeout_out       <= 1'b0;
      overrun_count_out <= '0;
      max_latency_out   <= '0;
    end else begin
      if (overrun_evt) begin
        overrun_out <= 1'b1;
        if (clear_in) begin
          overrun_count_out <= 8'd1;
        end else if (overrun_count_out != 8'hFF) begin
          overrun_count_out <= overrun_count_out + 8'd1;
        end
      end else if (clear_in) begin
        overrun_out       <= 1'b0;
        overrun_count_out <= '0;
      end

      if (timeout_evt) begin
        timeout_out <= 1'b1;
      end else if (clear_in) begin
        timeout_out <= 1'b0;
      end

      if (frame_done && (clear_in || (lat_next > max_latency_out))) begin
        max_latency_out <= lat_next;
      end else if (clear_in) begin
        max_latency_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_anc_frame_sequencer.sv
// Directed bench for anc_frame_sequencer: a responder answers each start after a programmable delay.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_anc_frame_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        sample_pulse_in;
  logic        adapt_en_in;
  logic        clear_in;
  logic        lp_done_in, lms_done_in, fir_done_in, dly_done_in;
  logic        lp_start_out, lms_start_out, fir_start_out, dly_start_out;
  logic        busy_out, abort_out, overrun_out, timeout_out;
  logic [7:0]  overrun_count_out;
  logic [15:0] last_latency_out, max_latency_out;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int cfg[4];
  int rem[4];
  int n_st[4];
  int t_st[4];
  int n_abort  = 0;
  logic [3:0] done_v;
  logic [3:0] start_v;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  assign lp_done_in  = done_v[0];
  assign lms_done_in = done_v[1];
  assign fir_done_in = done_v[2];
  assign dly_done_in = done_v[3];
  assign start_v = {dly_start_out, fir_start_out, lms_start_out, lp_start_out};

  anc_frame_sequencer dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .sample_pulse_in   (sample_pulse_in),
    .adapt_en_in       (adapt_en_in),
    .clear_in          (clear_in),
    .lp_done_in        (lp_done_in),
    .lms_done_in       (lms_done_in),
    .fir_done_in       (fir_done_in),
    .dly_done_in       (dly_done_in),
    .lp_start_out      (lp_start_out),
    .lms_start_out     (lms_start_out),
    .fir_start_out     (fir_start_out),
    .dly_start_out     (dly_start_out),
    .busy_out          (busy_out),
    .abort_out         (abort_out),
    .overrun_out       (overrun_out),
    .timeout_out       (timeout_out),
    .overrun_count_out (overrun_count_out),
    .last_latency_out  (last_latency_out),
    .max_latency_out   (max_latency_out)
  );

  // Stage model: done arrives cfg[i] cycles after the start; cfg[i]==0 withholds it.
  initial begin
    done_v = 4'b0;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      cfg[i] = 10;
    end
    forever begin
      @(negedge clk_in);
      done_v = 4'b0;
      if (!rst_n_in) begin
        for (int i = 0; i < 4; i++) rem[i] = 0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (rem[i] > 0) begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) done_v[i] = 1'b1;
          end
          if (start_v[i] && cfg[i] > 0) rem[i] = cfg[i];
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      n_st[i] = 0;
      t_st[i] = 0;
    end
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < 4; i++) begin
        if (start_v[i]) begin
          n_st[i] = n_st[i] + 1;
          t_st[i] = cyc;
        end
      end
      if (abort_out) n_abort = n_abort + 1;
    end
  end

  task automatic accept(input logic a);
    @(negedge clk_in);
    sample_pulse_in = 1'b1;
    adapt_en_in     = a;
    @(negedge clk_in);
    sample_pulse_in = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    @(negedge clk_in);
    while (busy_out && k < maxc) begin
      @(negedge clk_in);
      k++;
    end
    n_checks++;
    if (busy_out !== 1'b0) $display("FAIL %s_idle_wait busy=%0b required 0", nm, busy_out);
    else n_pass++;
  endtask

  task automatic wait_start(input int idx, input int maxc, input string nm);
    int k;
    k = 0;
    while (start_v[idx] !== 1'b1 && k < maxc) begin
      @(negedge clk_in);
      k++;
    end
    n_checks++;
    if (start_v[idx] !== 1'b1) $display("FAIL %s_start_wait start%0d=%0b required 1", nm, idx, start_v[idx]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; sample_pulse_in = 1'b0; adapt_en_in = 1'b0; clear_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({lp_start_out, lms_start_out, fir_start_out, dly_start_out} !== 4'b0)
      $display("FAIL rst_starts got %b required 0000", {lp_start_out, lms_start_out, fir_start_out, dly_start_out});
    else n_pass++;
    n_checks++;
    if ({busy_out, abort_out, overrun_out, timeout_out} !== 4'b0)
      $display("FAIL rst_flags got %b required 0000", {busy_out, abort_out, overrun_out, timeout_out});
    else n_pass++;
    n_checks++;
    if (overrun_count_out !== 8'd0 || last_latency_out !== 16'd0 || max_latency_out !== 16'd0)
      $display("FAIL rst_counters got cnt=%0d last=%0d max=%0d required 0", overrun_count_out, last_latency_out, max_latency_out);
    else n_pass++;
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_normal();
    int b_lp, b_lms, b_fir, b_dly;
    b_lp = n_st[0]; b_lms = n_st[1]; b_fir = n_st[2]; b_dly = n_st[3];
    accept(1'b1);
    n_checks++;
    if (lp_start_out !== 1'b1 || busy_out !== 1'b1)
      $display("FAIL norm_first_start got lp=%0b busy=%0b required 1 1", lp_start_out, busy_out);
    else n_pass++;
    wait_idle(200, "norm");
    n_checks++;
    if ({n_st[0] - b_lp, n_st[1] - b_lms, n_st[2] - b_fir, n_st[3] - b_dly} !== {32'd1, 32'd1, 32'd1, 32'd1})
      $display("FAIL norm_start_counts got %0d %0d %0d %0d required 1 1 1 1",
               n_st[0] - b_lp, n_st[1] - b_lms, n_st[2] - b_fir, n_st[3] - b_dly);
    else n_pass++;
    n_checks++;
    if (t_st[1] - t_st[0] != 11 || t_st[2] - t_st[1] != 11 || t_st[3] - t_st[2] != 11)
      $display("FAIL norm_start_spacing got %0d %0d %0d required 11 11 11",
               t_st[1] - t_st[0], t_st[2] - t_st[1], t_st[3] - t_st[2]);
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd44) $display("FAIL norm_last_latency got %0d required 44", last_latency_out);
    else n_pass++;
    n_checks++;
    if (max_latency_out !== 16'd44) $display("FAIL norm_max_latency got %0d required 44", max_latency_out);
    else n_pass++;
  endtask

  task automatic test_adapt_off();
    int b_lms;
    b_lms = n_st[1];
    accept(1'b0);
    repeat (5) @(negedge clk_in);
    adapt_en_in = 1'b1;
    wait_idle(200, "noadapt");
    n_checks++;
    if (n_st[1] != b_lms) $display("FAIL noadapt_lms_pulses got %0d required 0", n_st[1] - b_lms);
    else n_pass++;
    n_checks++;
    if (t_st[2] - t_st[0] != 11) $display("FAIL noadapt_fir_spacing got %0d required 11", t_st[2] - t_st[0]);
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd33) $display("FAIL noadapt_last_latency got %0d required 33", last_latency_out);
    else n_pass++;
    n_checks++;
    if (max_latency_out !== 16'd44) $display("FAIL noadapt_max_latency got %0d required 44", max_latency_out);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int b_dly;
    b_dly = n_st[3];
    accept(1'b1);
    wait_start(2, 100, "ovr");
    sample_pulse_in = 1'b1;
    @(negedge clk_in);
    sample_pulse_in = 1'b0;
    n_checks++;
    if (overrun_out !== 1'b1 || overrun_count_out !== 8'd1)
      $display("FAIL ovr_first got flag=%0b cnt=%0d required 1 1", overrun_out, overrun_count_out);
    else n_pass++;
    wait_idle(200, "ovr");
    n_checks++;
    if (n_st[3] - b_dly != 1 || last_latency_out !== 16'd44)
      $display("FAIL ovr_frame_completes got dly=%0d lat=%0d required 1 44", n_st[3] - b_dly, last_latency_out);
    else n_pass++;
    cfg[0] = 700;
    accept(1'b1);
    repeat (300) begin
      @(negedge clk_in);
      sample_pulse_in = 1'b1;
      @(negedge clk_in);
      sample_pulse_in = 1'b0;
    end
    n_checks++;
    if (overrun_count_out !== 8'd255) $display("FAIL ovr_saturate got %0d required 255", overrun_count_out);
    else n_pass++;
    wait_idle(1000, "ovr_long");
    cfg[0] = 10;
    n_checks++;
    if (last_latency_out !== 16'd734 || max_latency_out !== 16'd734)
      $display("FAIL ovr_long_latency got last=%0d max=%0d required 734 734", last_latency_out, max_latency_out);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int b_dly, b_ab, k, t_ab;
    b_dly = n_st[3];
    cfg[2] = 0;
    accept(1'b1);
    k = 0;
    while (abort_out !== 1'b1 && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    t_ab = cyc;
    b_ab = n_abort;
    n_checks++;
    if (abort_out !== 1'b1 || t_ab - t_st[2] != 1500)
      $display("FAIL tmo_abort_timing got abort=%0b delta=%0d required 1 1500", abort_out, t_ab - t_st[2]);
    else n_pass++;
    n_checks++;
    if (timeout_out !== 1'b1 || busy_out !== 1'b0)
      $display("FAIL tmo_flags got timeout=%0b busy=%0b required 1 0", timeout_out, busy_out);
    else n_pass++;
    @(negedge clk_in);
    n_checks++;
    if (abort_out !== 1'b0 || n_st[3] != b_dly)
      $display("FAIL tmo_after got abort=%0b dly_starts=%0d required 0 0", abort_out, n_st[3] - b_dly);
    else n_pass++;
    cfg[2] = 10;
    accept(1'b1);
    wait_idle(200, "tmo_next");
    n_checks++;
    if (n_st[3] - b_dly != 1 || last_latency_out !== 16'd44 || n_abort != b_ab)
      $display("FAIL tmo_next_frame got dly=%0d lat=%0d aborts=%0d required 1 44 0",
               n_st[3] - b_dly, last_latency_out, n_abort - b_ab);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int b_lp, b_ab;
    @(negedge clk_in);
    clear_in = 1'b1;
    @(negedge clk_in);
    clear_in = 1'b0;
    n_checks++;
    if ({overrun_out, timeout_out} !== 2'b00 || overrun_count_out !== 8'd0 || max_latency_out !== 16'd0)
      $display("FAIL clr_flags got ovr=%0b tmo=%0b cnt=%0d max=%0d required 0", overrun_out, timeout_out,
               overrun_count_out, max_latency_out);
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd44) $display("FAIL clr_keeps_last got %0d required 44", last_latency_out);
    else n_pass++;
    b_lp = n_st[0];
    accept(1'b1);
    wait_start(3, 100, "b2b");
    repeat (10) @(negedge clk_in);
    sample_pulse_in = 1'b1;
    @(negedge clk_in);
    sample_pulse_in = 1'b0;
    n_checks++;
    if (lp_start_out !== 1'b1 || busy_out !== 1'b1 || overrun_out !== 1'b0)
      $display("FAIL b2b_restart got lp=%0b busy=%0b ovr=%0b required 1 1 0", lp_start_out, busy_out, overrun_out);
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd44) $display("FAIL b2b_first_latency got %0d required 44", last_latency_out);
    else n_pass++;
    wait_idle(200, "b2b");
    n_checks++;
    if (n_st[0] - b_lp != 2 || overrun_count_out !== 8'd0 || max_latency_out !== 16'd44)
      $display("FAIL b2b_second got lp=%0d cnt=%0d max=%0d required 2 0 44", n_st[0] - b_lp,
               overrun_count_out, max_latency_out);
    else n_pass++;
    b_ab = n_abort;
    cfg[2] = 1499;
    accept(1'b1);
    wait_idle(2000, "expiry");
    cfg[2] = 10;
    n_checks++;
    if (n_abort != b_ab || timeout_out !== 1'b0)
      $display("FAIL expiry_done_wins got aborts=%0d tmo=%0b required 0 0", n_abort - b_ab, timeout_out);
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd1533 || max_latency_out !== 16'd1533)
      $display("FAIL expiry_latency got last=%0d max=%0d required 1533 1533", last_latency_out, max_latency_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int b_ab;
    b_ab = n_abort;
    cfg[1] = 0;
    accept(1'b1);
    wait_start(1, 100, "rstmid");
    repeat (3) @(negedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({busy_out, abort_out, overrun_out, timeout_out, lp_start_out, lms_start_out, fir_start_out, dly_start_out} !== 8'b0)
      $display("FAIL rstmid_bits got %b required 00000000",
               {busy_out, abort_out, overrun_out, timeout_out, lp_start_out, lms_start_out, fir_start_out, dly_start_out});
    else n_pass++;
    n_checks++;
    if (last_latency_out !== 16'd0 || max_latency_out !== 16'd0 || overrun_count_out !== 8'd0)
      $display("FAIL rstmid_counters got last=%0d max=%0d cnt=%0d required 0", last_latency_out, max_latency_out,
               overrun_count_out);
    else n_pass++;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    cfg[1] = 10;
    repeat (2) @(negedge clk_in);
    n_checks++;
    if (n_abort != b_ab || busy_out !== 1'b0)
      $display("FAIL rstmid_no_abort got aborts=%0d busy=%0b required 0 0", n_abort - b_ab, busy_out);
    else n_pass++;
  endtask

  task automatic test_clear_vs_overrun();
    cfg[0] = 20;
    accept(1'b1);
    repeat (3) @(negedge clk_in);
    sample_pulse_in = 1'b1;
    clear_in        = 1'b1;
    @(negedge clk_in);
    sample_pulse_in = 1'b0;
    clear_in        = 1'b0;
    n_checks++;
    if (overrun_out !== 1'b1) $display("FAIL clrovr_set_wins got %0b required 1", overrun_out);
    else n_pass++;
    wait_idle(200, "clrovr");
    cfg[0] = 10;
    n_checks++;
    if (last_latency_out !== 16'd54) $display("FAIL clrovr_latency got %0d required 54", last_latency_out);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_adapt_off();
    test_overrun();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_clear_vs_overrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/anc_frame_sequencer.md
# anc_frame_sequencer

Per-sample controller for the adaptive noise-cancellation datapath. It sits between the I2S receiver's new-sample pulse and the processing chain: lowpass pair, then NLMS coefficient update, then FIR, then delay/scale. It issues one start pulse to each stage in turn and waits for that stage's done pulse before moving on. It also detects sample overruns and stalled stages, measures per-frame latency, and can freeze adaptation by skipping the NLMS stage.

## Interface
- TIMEOUT_CYCLES, 1500: maximum cycles to wait for any single stage done; fits within one 64 kHz sample period at 100 MHz.
- LAT_W, 16: width of the latency counters.
- clk_in  input  1  system clock, 100 MHz.
- rst_n_in  input  1  asynchronous, active-low reset.
- sample_pulse_in  input  1  one-cycle pulse when a new mic sample pair is valid.
- adapt_en_in  input  1  1 = run NLMS stage; 0 = coefficients frozen, NLMS skipped.
- clear_in  input  1  synchronous clear of sticky flags and counters.
- lp_done_in, lms_done_in, fir_done_in, dly_done_in  input  1 each  stage done pulses.
- lp_start_out, lms_start_out, fir_start_out, dly_start_out  output  1 each  one-cycle stage start pulses.
- busy_out  output  1  high whenever the state is not IDLE.
- abort_out  output  1  one-cycle pulse when a frame is abandoned on timeout.
- overrun_out  output  1  sticky; a sample pulse arrived while busy.
- timeout_out  output  1  sticky; a stage exceeded TIMEOUT_CYCLES.
- overrun_count_out  output  8  saturating count of dropped sample pulses.
- last_latency_out  output  LAT_W  cycles from accept to dly_done for the most recent completed frame.
- max_latency_out  output  LAT_W  maximum of last_latency_out since reset or clear.

## Operation
- States: IDLE, LP_WAIT, LMS_WAIT, FIR_WAIT, DLY_WAIT.
- IDLE, sample_pulse_in=1: accept the frame.
  - Latch adapt_en_in into adapt_q.
  - Next cycle: lp_start_out=1 and state becomes LP_WAIT.
- LP_WAIT, lp_done_in=1: if adapt_q=1, pulse lms_start_out and go to LMS_WAIT; otherwise pulse fir_start_out and go to FIR_WAIT.
- LMS_WAIT, lms_done_in=1: pulse fir_start_out, go to FIR_WAIT.
- FIR_WAIT, fir_done_in=1: pulse dly_start_out, go to DLY_WAIT.
- DLY_WAIT, dly_done_in=1:
  - Update last_latency_out; update max_latency_out if exceeded.
  - Go to IDLE.
  - If sample_pulse_in=1 in the same cycle, accept it as a new frame; this is not an overrun.
- sample_pulse_in while busy (other than the case above):
  - Drop the pulse.
  - Set overrun_out.
  - Increment overrun_count_out, saturating at 255.
  - The current frame continues.
- Done pulses that do not match the current state are ignored.
- Stage timer: reloads to 0 on every start pulse and increments in each wait state. When it reaches TIMEOUT_CYCLES-1 with no matching done:
  - Set timeout_out.
  - Pulse abort_out.
  - Go to IDLE; no further start pulses for that frame.
  - A done arriving in the expiry cycle wins over the timeout.
- Latency counter: 0 at accept, increments every busy cycle, saturates at all-ones.
- clear_in zeros overrun_out, timeout_out, overrun_count_out and max_latency_out. It does not affect state or last_latency_out. If clear_in and a set event occur in the same cycle, the set wins.

## Timing
- Reset values: all outputs are 0, state is IDLE, adapt_q=0.
- Async assert; the synchronized deassert is handled externally.
- Reset mid-frame aborts immediately with no abort_out pulse.
- All outputs are registered.
- Every start pulse is exactly one cycle wide, issued the cycle after its trigger.
- Sequencer overhead: 1 cycle per stage. Frame latency = 4 + sum of stage latencies, or 3 + sum when adaptation is disabled.
- busy_out rises the cycle after accept and falls the cycle after dly_done_in.

## Structure
- Shared package anc_pkg holds:
  - the state enum typedef anc_seq_state_t;
  - localparam SAMPLE_PERIOD_CYCLES = 1562;
  - default TIMEOUT_CYCLES.
- Sub-module stage_watchdog: the loadable timer with an expire pulse. It is reusable by the other control blocks in the ANC chain.
- Instantiated in the top level to drive the existing lowpass, NLMS, FIR and delay/scale ready inputs.

## Test plan
- Normal frame, adapt_en_in=1, each done 10 cycles after its start: four start pulses in order; last_latency_out=44; busy_out low afterwards.
- adapt_en_in=0 at accept, toggled to 1 mid-frame: lms_start_out never pulses; last_latency_out=33 with 10-cycle stages.
- Second sample_pulse_in during FIR_WAIT: overrun_out=1 and overrun_count_out=1; frame completes normally. Then 300 overruns: count holds at 255.
- fir_done_in withheld: abort_out pulses exactly TIMEOUT_CYCLES cycles after fir_start_out; timeout_out=1; dly_start_out never pulses. The next sample_pulse_in is accepted.
- dly_done_in and sample_pulse_in in the same cycle: no overrun; lp_start_out on the next cycle. Done in the timer-expiry cycle: no abort.
- Assert rst_n_in in LMS_WAIT: all outputs 0 immediately, no abort_out. clear_in concurrent with an overrun: overrun_out stays 1.
